// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key tracker: Set-2 prefix bytes, the list of
// protocol bytes that never form a key event, decoder states and the event record.
package ps2_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  // Keyboard housekeeping / error replies: abort any prefix, never queued
  localparam int unsigned NUM_DROP = 9;
  localparam logic [7:0] DROP_CODES [NUM_DROP] =
    '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } ps2_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  localparam int unsigned EVT_W = $bits(ps2_event_t);

  function automatic logic is_dropped(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_DROP; i++)
      if (b == DROP_CODES[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO for decoded key events. Head data is valid
// whenever empty is low; a push while full is accepted only alongside a pop.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 key tracker: decodes make/break/E0 sequences from PS2_Controller,
// keeps a table of held keys and queues key events in a FWFT FIFO.
// Build option: define REPEAT_FILTER_EN to suppress queueing of typematic
// repeat makes (keys already held).
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [7:0]                      received_data,
  input  logic                            received_data_en,
  input  logic                            evt_ready,
  output logic                            evt_valid,
  output logic [7:0]                      evt_code,
  output logic                            evt_ext,
  output logic                            evt_break,
  output logic [9*NUM_KEYS-1:0]           held_codes,
  output logic [NUM_KEYS-1:0]             held_valid,
  output logic [$clog2(NUM_KEYS+1)-1:0]   held_count,
  output logic [1:0]                      overflow,
  output logic [7:0]                      last_data_received
);

  localparam int unsigned CNT_W   = $clog2(NUM_KEYS + 1);
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state;
  logic [TO_W-1:0]  to_cnt;
  ps2_event_t       dec_evt;
  logic             dec_push;
  logic [8:0]       dec_key;
  logic [8:0]       slot_key [NUM_KEYS];
  logic [NUM_KEYS-1:0] hit_vec;
  logic [NUM_KEYS-1:0] free_oh;
  logic             found_free;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  logic [EVT_W-1:0] head_raw;
  ps2_event_t       head;

  // Decode the strobed byte against the current prefix state into an event
  always_comb begin
    dec_push     = 1'b0;
    dec_evt      = '0;
    dec_evt.code = received_data;
    if (received_data_en && !is_dropped(received_data) &&
        received_data != PFX_E0 && received_data != PFX_F0) begin
      dec_push = 1'b1;
      unique case (state)
        ST_IDLE:     dec_evt.ext = 1'b0;
        ST_GOT_E0:   dec_evt.ext = 1'b1;
        ST_GOT_F0:   dec_evt.brk = 1'b1;
        ST_GOT_E0F0: begin dec_evt.brk = 1'b1; dec_evt.ext = 1'b1; end
      endcase
    end
  end

  assign dec_key = {dec_evt.ext, dec_evt.code};

  // Prefix FSM with stale-prefix timeout; the counter only runs outside IDLE
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else if (received_data_en) begin
      to_cnt <= '0;
      if (is_dropped(received_data)) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE:
            if (received_data == PFX_E0)      state <= ST_GOT_E0;
            else if (received_data == PFX_F0) state <= ST_GOT_F0;
            else                              state <= ST_IDLE;
          ST_GOT_E0:
            if (received_data == PFX_F0)      state <= ST_GOT_E0F0;
            else if (received_data == PFX_E0) state <= ST_GOT_E0;
            else                              state <= ST_IDLE;
          ST_GOT_F0, ST_GOT_E0F0:             state <= ST_IDLE;
        endcase
      end
    end else if (state != ST_IDLE) begin
      if (to_cnt == TO_LAST) begin
        state  <= ST_IDLE;
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end

  // Look up the decoded key in the table and find the lowest free slot
  always_comb begin
    hit_vec    = '0;
    free_oh    = '0;
    found_free = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (held_valid[i] && slot_key[i] == dec_key) hit_vec[i] = 1'b1;
      if (!held_valid[i] && !found_free) begin
        free_oh[i] = 1'b1;
        found_free = 1'b1;
      end
    end
  end

`ifdef REPEAT_FILTER_EN
  assign fifo_push = dec_push && !(!dec_evt.brk && (|hit_vec));
`else
  assign fifo_push = dec_push;
`endif

  assign fifo_drop = fifo_push && fifo_full && !(evt_ready && !fifo_empty);

  // Held-key table and sticky overflow flags
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_valid <= '0;
      overflow   <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) slot_key[i] <= '0;
    end else begin
      if (fifo_drop) overflow[0] <= 1'b1;
      if (dec_push && !dec_evt.brk && !(|hit_vec) && !found_free) overflow[1] <= 1'b1;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (dec_push && !dec_evt.brk && !(|hit_vec) && free_oh[i]) begin
          held_valid[i] <= 1'b1;
          slot_key[i]   <= dec_key;
        end else if (dec_push && dec_evt.brk && hit_vec[i]) begin
          held_valid[i] <= 1'b0;
          slot_key[i]   <= '0;
        end
      end
    end
  end

  // Raw byte capture, including prefixes and dropped bytes
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) last_data_received <= 8'h00;
    else if (received_data_en) last_data_received <= received_data;
  end

  // Flatten the table and count occupied slots
  always_comb begin
    held_codes = '0;
    held_count = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      held_codes[9*i +: 9] = slot_key[i];
      held_count = held_count + CNT_W'(held_valid[i]);
    end
  end

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (dec_evt),
    .pop       (evt_ready),
    .pop_data  (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head      = ps2_event_t'(head_raw);
  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_ext   = evt_valid && head.ext;
  assign evt_break = evt_valid && head.brk;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_ps2_key_tracker;

  localparam int unsigned NK  = 4;
  localparam int unsigned FD  = 8;
  localparam int unsigned TO  = 64;

  logic            CLOCK_50 = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      received_data = '0;
  logic            received_data_en = 1'b0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [7:0]      evt_code;
  logic            evt_ext;
  logic            evt_break;
  logic [9*NK-1:0] held_codes;
  logic [NK-1:0]   held_valid;
  logic [2:0]      held_count;
  logic [1:0]      overflow;
  logic [7:0]      last_data_received;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50           (CLOCK_50),
    .reset              (reset),
    .received_data      (received_data),
    .received_data_en   (received_data_en),
    .evt_ready          (evt_ready),
    .evt_valid          (evt_valid),
    .evt_code           (evt_code),
    .evt_ext            (evt_ext),
    .evt_break          (evt_break),
    .held_codes         (held_codes),
    .held_valid         (held_valid),
    .held_count         (held_count),
    .overflow           (overflow),
    .last_data_received (last_data_received)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- reference model ----------------
  typedef struct { bit brk; bit ext; bit [7:0] code; } mevt_t;
  mevt_t    mq[$];
  bit [7:0] pend[$];
  bit [8:0] m_key [NK];
  bit       m_v   [NK];
  bit [1:0] m_ovf;
  bit [7:0] m_last;
  int       m_idle;

  function automatic bit m_dropped(input bit [7:0] b);
    return (b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hEE || b == 8'hFA ||
            b >= 8'hFC);
  endfunction

  function automatic bit pend_has(input bit [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    for (int i = 0; i < NK; i++) begin m_key[i] = '0; m_v[i] = 1'b0; end
    m_ovf = '0; m_last = '0; m_idle = 0;
  endtask

  task automatic model_edge(input bit en, input bit [7:0] d, input bit rdy);
    bit    do_pop, have, push;
    mevt_t e;
    int    idx, fr;
    do_pop = rdy && (mq.size() > 0);
    have = 1'b0; push = 1'b0;
    e = '{1'b0, 1'b0, 8'h00};
    if (en) begin
      m_last = d; m_idle = 0;
      if (m_dropped(d)) pend.delete();
      else if (d == 8'hE0) begin
        if (pend_has(8'hF0)) pend.delete();
        else if (pend.size() == 0) pend.push_back(d);
      end else if (d == 8'hF0) begin
        if (pend_has(8'hF0)) pend.delete();
        else pend.push_back(d);
      end else begin
        have = 1'b1;
        e.ext = pend_has(8'hE0); e.brk = pend_has(8'hF0); e.code = d;
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin pend.delete(); m_idle = 0; end
    end
    if (have) begin
      push = 1'b1;
      idx = -1; fr = -1;
      for (int i = NK - 1; i >= 0; i--) begin
        if (m_v[i] && m_key[i] == {e.ext, e.code}) idx = i;
        if (!m_v[i]) fr = i;
      end
      if (!e.brk) begin
        if (idx < 0) begin
          if (fr >= 0) begin m_v[fr] = 1'b1; m_key[fr] = {e.ext, e.code}; end
          else m_ovf[1] = 1'b1;
        end
`ifdef REPEAT_FILTER_EN
        else push = 1'b0;
`endif
      end else if (idx >= 0) begin
        m_v[idx] = 1'b0; m_key[idx] = '0;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < FD) mq.push_back(e);
      else m_ovf[0] = 1'b1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [9*NK-1:0] ec;
    logic [NK-1:0]   ev;
    int              cnt;
    mevt_t           h;
    ec = '0; ev = '0; cnt = 0;
    for (int i = 0; i < NK; i++) begin
      ec[9*i +: 9] = m_key[i];
      ev[i] = m_v[i];
      cnt += int'(m_v[i]);
    end
    h = (mq.size() > 0) ? mq[0] : '{1'b0, 1'b0, 8'h00};
    chk({tag, "_valid"}, evt_valid, mq.size() > 0);
    chk({tag, "_code"},  evt_code,  h.code);
    chk({tag, "_ext"},   evt_ext,   h.ext);
    chk({tag, "_brk"},   evt_break, h.brk);
    chk({tag, "_codes"}, held_codes, ec);
    chk({tag, "_hvalid"}, held_valid, ev);
    chk({tag, "_hcount"}, held_count, cnt);
    chk({tag, "_ovf"},   overflow,  m_ovf);
    chk({tag, "_last"},  last_data_received, m_last);
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic rdy);
    received_data_en = en;
    received_data    = d;
    evt_ready        = rdy;
    model_edge(en, d, rdy);
    @(posedge CLOCK_50);
    #1;
    received_data_en = 1'b0;
    evt_ready        = 1'b0;
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    received_data_en = 1'b0;
    evt_ready        = 1'b0;
    received_data    = '0;
    reset            = 1'b1;
    #2;
    model_reset();
    compare_all("rst");
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(posedge CLOCK_50);
    #1;
    compare_all("post_rst");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       rdy;
    logic       valid;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] hv;
    logic [2:0] cnt;
    logic [8:0] slot0;
  } vec_t;

  vec_t     tbl [12];
  logic [7:0] pool [15];

  initial begin
    int npop;

    tbl[0]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 4'h1, 3'd1, 9'h01C};
    tbl[1]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 4'h1, 3'd1, 9'h01C};
    tbl[2]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 4'h0, 3'd0, 9'h000};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b1, 4'h0, 3'd0, 9'h000};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 3'd0, 9'h000};
    tbl[5]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 3'd0, 9'h000};
    tbl[6]  = '{1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 4'h1, 3'd1, 9'h175};
    tbl[7]  = '{1'b1, 8'hE0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 4'h1, 3'd1, 9'h175};
    tbl[8]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 4'h1, 3'd1, 9'h175};
    tbl[9]  = '{1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 4'h0, 3'd0, 9'h000};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 4'h0, 3'd0, 9'h000};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 3'd0, 9'h000};

    pool = '{8'h1C, 8'h1D, 8'h24, 8'h2D, 8'h3C, 8'h75, 8'h6B, 8'hE0,
             8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h00};

    #1;
    do_reset();

    // make/break sequences, plain and extended
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].data, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_code", i),  evt_code,  tbl[i].code);
      chk($sformatf("tbl%0d_ext", i),   evt_ext,   tbl[i].ext);
      chk($sformatf("tbl%0d_brk", i),   evt_break, tbl[i].brk);
      chk($sformatf("tbl%0d_hv", i),    held_valid, tbl[i].hv);
      chk($sformatf("tbl%0d_cnt", i),   held_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_slot0", i), held_codes[8:0], tbl[i].slot0);
    end

    // table full on the fifth distinct make
    do_reset();
    step(1'b1, 8'h15, 1'b0);
    step(1'b1, 8'h1D, 1'b0);
    step(1'b1, 8'h24, 1'b0);
    step(1'b1, 8'h2D, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    chk("tblfull_hv", held_valid, 4'hF);
    chk("tblfull_codes", held_codes, {9'h02D, 9'h024, 9'h01D, 9'h015});
    chk("tblfull_ovf", overflow, 2'b10);
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      if (evt_valid) npop++;
      step(1'b0, 8'h00, 1'b1);
    end
    chk("tblfull_events", npop, 5);

    // FIFO overflow, then push accepted alongside a pop while full
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'h1C, 1'b0);
    chk("fifofull_ovf", overflow, 2'b01);
    chk("fifofull_hcount", held_count, 3'd1);
    step(1'b1, 8'h1C, 1'b1);
    chk("fifo_pushpop_ovf", overflow, 2'b01);
    npop = 0;
    for (int i = 0; i < 12; i++) begin
      if (evt_valid) npop++;
      step(1'b0, 8'h00, 1'b1);
    end
    chk("fifo_pushpop_count", npop, 8);

    // prefix timeout boundaries: TO-1 idle cycles keeps F0, TO idle cycles drops it
    do_reset();
    step(1'b1, 8'hF0, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'h1C, 1'b0);
    chk("to_keep_valid", evt_valid, 1'b1);
    chk("to_keep_brk", evt_break, 1'b1);
    do_reset();
    step(1'b1, 8'hF0, 1'b0);
    idle(TO);
    step(1'b1, 8'h1C, 1'b0);
    chk("to_expire_brk", evt_break, 1'b0);
    chk("to_expire_code", evt_code, 8'h1C);
    chk("to_expire_hv", held_valid, 4'h1);

    // dropped bytes, and a dropped byte aborting an E0 prefix
    do_reset();
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hFA, 1'b0);
    chk("drop_valid", evt_valid, 1'b0);
    chk("drop_last", last_data_received, 8'hFA);
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h75, 1'b0);
    chk("drop_abort_ext", evt_ext, 1'b0);
    chk("drop_abort_code", evt_code, 8'h75);

    // reset in the middle of an extended sequence
    do_reset();
    step(1'b1, 8'hE0, 1'b0);
    do_reset();
    step(1'b1, 8'h75, 1'b0);
    chk("rstmid_ext", evt_ext, 1'b0);
    chk("rstmid_code", evt_code, 8'h75);
    chk("rstmid_brk", evt_break, 1'b0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) idle(int'($urandom_range(TO - 2, TO + 2)));
      else if ($urandom_range(0, 599) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 14)],
                ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
